// File: rtl/cache_controller_pkg.sv
// Shared sizing and FSM encoding for the 2-way write-through data cache.
// Optional statistics counters are enabled by defining CACHE_STATS_EN.
package cache_controller_pkg;

  localparam int CC_SETS = 64;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int IDX_W   = $clog2(CC_SETS);
  localparam int TAG_W   = ADDR_W - IDX_W - 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_MISS = 2'd1,
    ST_WRITE   = 2'd2
  } cc_state_e;

endpackage

// File: rtl/cache_controller_if.sv
// MEM-stage and SRAM-side buses of the data cache.
// Handshake: a request (wrEn/rdEn) is held stable until ready=1 is seen; that cycle completes it.
interface cache_mem_if;
  import cache_controller_pkg::*;

  logic              wrEn;
  logic              rdEn;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writeData;
  logic [DATA_W-1:0] readData;
  logic              ready;

  modport master (output wrEn, rdEn, address, writeData, input readData, ready);
  modport slave  (input wrEn, rdEn, address, writeData, output readData, ready);
endinterface

interface cache_sram_if;
  import cache_controller_pkg::*;

  logic              sram_wrEn;
  logic              sram_rdEn;
  logic [ADDR_W-1:0] sram_address;
  logic [DATA_W-1:0] sram_writeData;
  logic [DATA_W-1:0] sram_readData;
  logic              sram_ready;

  modport master (output sram_wrEn, sram_rdEn, sram_address, sram_writeData,
                  input sram_readData, sram_ready);
  modport slave  (input sram_wrEn, sram_rdEn, sram_address, sram_writeData,
                  output sram_readData, sram_ready);
endinterface

// File: rtl/cache_controller_way_array.sv
// One way of the cache: per-set valid/tag/data, combinational read, synchronous write.
// Only the valid bits are cleared by reset; tag/data are qualified by valid.
module cache_way_array
  import cache_controller_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  idx_i,
  output logic              valid_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              we_i,
  input  logic [TAG_W-1:0]  wtag_i,
  input  logic [DATA_W-1:0] wdata_i
);

  logic [CC_SETS-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q  [CC_SETS];
  logic [DATA_W-1:0]  data_q [CC_SETS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[idx_i]  <= wtag_i;
      data_q[idx_i] <= wdata_i;
    end
  end

  assign valid_o = valid_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign data_o  = data_q[idx_i];

endmodule

// File: rtl/cache_controller.sv
// 2-way set-associative, write-through, read-allocate data cache in front of SRAM_Controller.
// Define CACHE_STATS_EN to build the saturating hit/miss counters.
module cache_controller
  import cache_controller_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  cache_mem_if.slave        mem,
  cache_sram_if.master      sram,
  output logic [15:0]       hitCount,
  output logic [15:0]       missCount,
  output cc_state_e         dbg_state_o
);

  cc_state_e state_q, state_d;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              v0, v1;
  logic [TAG_W-1:0]  t0, t1;
  logic [DATA_W-1:0] d0, d1;
  logic              hit0, hit1, hit;
  logic              we0, we1;
  logic [DATA_W-1:0] wdata;
  logic              victim1;
  logic [CC_SETS-1:0] lru_q;
  logic              lru_cur, lru_we, lru_d;
  logic              ready_c, sram_rd_c, sram_wr_c;
  logic              hit_evt, miss_evt;

  assign idx = mem.address[IDX_W+1:2];
  assign tag = mem.address[ADDR_W-1:IDX_W+2];

  cache_way_array u_way0 (
    .clk     (clk),
    .rst     (rst),
    .idx_i   (idx),
    .valid_o (v0),
    .tag_o   (t0),
    .data_o  (d0),
    .we_i    (we0),
    .wtag_i  (tag),
    .wdata_i (wdata)
  );

  cache_way_array u_way1 (
    .clk     (clk),
    .rst     (rst),
    .idx_i   (idx),
    .valid_o (v1),
    .tag_o   (t1),
    .data_o  (d1),
    .we_i    (we1),
    .wtag_i  (tag),
    .wdata_i (wdata)
  );

  assign hit0    = v0 && (t0 == tag);
  assign hit1    = v1 && (t1 == tag);
  assign hit     = hit0 | hit1;
  assign lru_cur = lru_q[idx];
  // Fill order: invalid way0, then invalid way1, then whichever way LRU names.
  assign victim1 = v0 & (~v1 | lru_cur);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lru_q <= '0;
    end else if (lru_we) begin
      lru_q[idx] <= lru_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ready_c   = 1'b0;
    sram_rd_c = 1'b0;
    sram_wr_c = 1'b0;
    we0       = 1'b0;
    we1       = 1'b0;
    wdata     = mem.writeData;
    lru_we    = 1'b0;
    lru_d     = lru_cur;
    hit_evt   = 1'b0;
    miss_evt  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_c = ~(mem.wrEn | mem.rdEn) | (mem.rdEn & ~mem.wrEn & hit);
        if (mem.wrEn) begin
          state_d = ST_WRITE;
          // Write hit refreshes the cached copy now; a write miss does not allocate.
          if (hit) begin
            we0    = hit0;
            we1    = hit1;
            lru_we = 1'b1;
            lru_d  = hit0;
          end
        end else if (mem.rdEn) begin
          if (hit) begin
            lru_we  = 1'b1;
            lru_d   = hit0;
            hit_evt = 1'b1;
          end else begin
            state_d  = ST_RD_MISS;
            miss_evt = 1'b1;
          end
        end
      end
      ST_RD_MISS: begin
        sram_rd_c = 1'b1;
        ready_c   = sram.sram_ready;
        wdata     = sram.sram_readData;
        if (sram.sram_ready) begin
          we0     = ~victim1;
          we1     = victim1;
          lru_we  = 1'b1;
          lru_d   = ~victim1;
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        sram_wr_c = 1'b1;
        ready_c   = sram.sram_ready;
        if (sram.sram_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign mem.ready           = ready_c;
  assign mem.readData        = (state_q == ST_RD_MISS) ? sram.sram_readData
                                                       : (hit1 ? d1 : d0);
  assign sram.sram_rdEn      = sram_rd_c;
  assign sram.sram_wrEn      = sram_wr_c;
  assign sram.sram_address   = mem.address;
  assign sram.sram_writeData = mem.writeData;
  assign dbg_state_o         = state_q;

`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_evt && (hit_cnt_q != 16'hFFFF)) begin
        hit_cnt_q <= hit_cnt_q + 16'd1;
      end
      if (miss_evt && (miss_cnt_q != 16'hFFFF)) begin
        miss_cnt_q <= miss_cnt_q + 16'd1;
      end
    end
  end

  assign hitCount  = hit_cnt_q;
  assign missCount = miss_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = hit_evt ^ miss_evt;
  assign hitCount     = 16'h0;
  assign missCount    = 16'h0;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: SRAM responder, LRU-list reference model, per-cycle compare.
module tb_cache_controller;
  import cache_controller_pkg::*;

  logic        clk;
  logic        rst;
  logic [15:0] hitCount, missCount;
  cc_state_e   dbg_state;

  cache_mem_if  mif();
  cache_sram_if sif();

  cache_controller dut (
    .clk         (clk),
    .rst         (rst),
    .mem         (mif.slave),
    .sram        (sif.master),
    .hitCount    (hitCount),
    .missCount   (missCount),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- SRAM model ----------------
  logic [31:0] sram_mem [logic [29:0]];
  int          sram_lat = 2;
  int          sram_cnt = 0;

  function automatic logic [31:0] sram_rd(input logic [31:0] a);
    if (sram_mem.exists(a[31:2])) return sram_mem[a[31:2]];
    return {~a[15:0], a[15:0]};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      sram_cnt = 0;
      sif.sram_ready = 1'b0;
    end else if (sif.sram_ready) begin
      sif.sram_ready = 1'b0;
      sram_cnt = 0;
    end else if (sif.sram_rdEn || sif.sram_wrEn) begin
      sram_cnt++;
      if (sram_cnt >= sram_lat) begin
        sif.sram_ready = 1'b1;
        if (sif.sram_wrEn) sram_mem[sif.sram_address[31:2]] = sif.sram_writeData;
        else sif.sram_readData = sram_rd(sif.sram_address);
      end
    end else begin
      sram_cnt = 0;
    end
  end

  // ---------------- reference model: per-set MRU-ordered list ----------------
  int          m_cnt [CC_SETS];
  logic [TAG_W-1:0] m_tag [CC_SETS][2];
  logic [31:0] m_dat [CC_SETS][2];
  int          exp_hit = 0;
  int          exp_miss = 0;

  function automatic int m_set(input logic [31:0] a);
    return int'(a[IDX_W+1:2]);
  endfunction

  function automatic int m_find(input logic [31:0] a);
    int s = m_set(a);
    for (int i = 0; i < m_cnt[s]; i++)
      if (m_tag[s][i] == a[31:IDX_W+2]) return i;
    return -1;
  endfunction

  function automatic void m_touch(input logic [31:0] a, input int pos);
    int s = m_set(a);
    logic [TAG_W-1:0] tt;
    logic [31:0] dd;
    if (pos == 1) begin
      tt = m_tag[s][1]; dd = m_dat[s][1];
      m_tag[s][1] = m_tag[s][0]; m_dat[s][1] = m_dat[s][0];
      m_tag[s][0] = tt; m_dat[s][0] = dd;
    end
  endfunction

  function automatic void m_fill(input logic [31:0] a, input logic [31:0] d);
    int s = m_set(a);
    m_tag[s][1] = m_tag[s][0];
    m_dat[s][1] = m_dat[s][0];
    m_tag[s][0] = a[31:IDX_W+2];
    m_dat[s][0] = d;
    if (m_cnt[s] < 2) m_cnt[s]++;
  endfunction

  function automatic void m_write(input logic [31:0] a, input logic [31:0] d);
    int p = m_find(a);
    if (p >= 0) begin
      m_dat[m_set(a)][p] = d;
      m_touch(a, p);
    end
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < CC_SETS; i++) m_cnt[i] = 0;
    exp_hit = 0;
    exp_miss = 0;
  endfunction

  // ---------------- compare process ----------------
  logic        chk_en = 1'b0;
  int          k = 0;
  logic        is_wr, req_hit;
  logic [31:0] hit_data;

  always @(negedge clk) begin
    #2;
    if (chk_en) begin
`ifdef CACHE_STATS_EN
      chk("hitCount", 32'(hitCount), 32'(exp_hit));
      chk("missCount", 32'(missCount), 32'(exp_miss));
`else
      chk("hitCount_off", 32'(hitCount), 32'h0);
      chk("missCount_off", 32'(missCount), 32'h0);
`endif
      if (!(mif.rdEn || mif.wrEn)) begin
        k = 0;
        chk("idle_ready", 32'(mif.ready), 32'h1);
        chk("idle_sram_rdEn", 32'(sif.sram_rdEn), 32'h0);
        chk("idle_sram_wrEn", 32'(sif.sram_wrEn), 32'h0);
      end else begin
        logic en_exp, rdy_exp;
        if (k == 0) begin
          int p;
          is_wr   = mif.wrEn;
          p       = m_find(mif.address);
          req_hit = !is_wr && (p >= 0);
          hit_data = (p >= 0) ? m_dat[m_set(mif.address)][p] : 32'h0;
        end
        en_exp  = !req_hit && (k >= 1);
        rdy_exp = req_hit || ((k >= 1) && sif.sram_ready);
        chk("ready", 32'(mif.ready), 32'(rdy_exp));
        chk("sram_rdEn", 32'(sif.sram_rdEn), 32'(en_exp && !is_wr));
        chk("sram_wrEn", 32'(sif.sram_wrEn), 32'(en_exp && is_wr));
        if (en_exp) begin
          chk("sram_address", sif.sram_address, mif.address);
          chk("sram_writeData", sif.sram_writeData, mif.writeData);
        end
        if (rdy_exp && !is_wr)
          chk("readData", mif.readData, req_hit ? hit_data : sram_rd(mif.address));
        if (k == 0 && is_wr) m_write(mif.address, mif.writeData);
        if (k == 0 && req_hit) begin
          exp_hit++;
          m_touch(mif.address, m_find(mif.address));
        end
        if (k == 0 && !is_wr && !req_hit) exp_miss++;
        if (!is_wr && !req_hit && rdy_exp) m_fill(mif.address, sif.sram_readData);
        k++;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_req(input logic wr, input logic rd, input logic [31:0] a,
                        input logic [31:0] d, input int lat,
                        output int cyc, output logic [31:0] rdat);
    logic done;
    @(negedge clk);
    mif.wrEn = wr; mif.rdEn = rd; mif.address = a; mif.writeData = d;
    sram_lat = lat;
    cyc = 0; done = 1'b0; rdat = 32'h0;
    while (!done && cyc < 200) begin
      #3;
      if (mif.ready) begin
        done = 1'b1;
        rdat = mif.readData;
      end else begin
        cyc++;
        @(negedge clk);
      end
    end
    if (!done) chk("req_timeout", 32'(cyc), 32'h0);
    @(negedge clk);
    mif.wrEn = 1'b0; mif.rdEn = 1'b0;
  endtask

  // ---------------- directed tests ----------------
  int          cyc;
  logic [31:0] rdat;

  initial begin
    rst = 1'b0;
    mif.wrEn = 1'b0; mif.rdEn = 1'b0; mif.address = 32'h0; mif.writeData = 32'h0;
    sif.sram_ready = 1'b0; sif.sram_readData = 32'h0;
    m_clear();
    sram_mem[30'(32'h400 >> 2)] = 32'hDEADBEEF;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_ready", 32'(mif.ready), 32'h1);
    chk("rst_sram_rdEn", 32'(sif.sram_rdEn), 32'h0);
    chk("rst_sram_wrEn", 32'(sif.sram_wrEn), 32'h0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rst_hitCount", 32'(hitCount), 32'h0);
    chk("rst_missCount", 32'(missCount), 32'h0);
    @(negedge clk);
    rst = 1'b1; k = 0; chk_en = 1'b1;

    // 1: cold miss then hit
    do_req(1'b0, 1'b1, 32'h400, 32'h0, 6, cyc, rdat);
    chk("t1_miss_cycles", 32'(cyc), 32'd6);
    chk("t1_miss_data", rdat, 32'hDEADBEEF);
    do_req(1'b0, 1'b1, 32'h400, 32'h0, 6, cyc, rdat);
    chk("t1_hit_cycles", 32'(cyc), 32'd0);
    chk("t1_hit_data", rdat, 32'hDEADBEEF);
    chk("t1_model_hit", 32'(m_find(32'h400)), 32'd0);
`ifdef CACHE_STATS_EN
    chk("t1_hitCount", 32'(hitCount), 32'd1);
    chk("t1_missCount", 32'(missCount), 32'd1);
`endif

    // 2: write miss (no allocate)
    do_req(1'b1, 1'b0, 32'h404, 32'h12345678, 3, cyc, rdat);
    chk("t2_wr_cycles", 32'(cyc), 32'd3);
    chk("t2_sram_written", sram_rd(32'h404), 32'h12345678);
    do_req(1'b0, 1'b1, 32'h404, 32'h0, 3, cyc, rdat);
    chk("t2_rd_miss_cycles", 32'(cyc), 32'd3);
    chk("t2_rd_data", rdat, 32'h12345678);

    // 3: write hit updates cache
    do_req(1'b1, 1'b0, 32'h400, 32'hCAFEF00D, 2, cyc, rdat);
    chk("t3_wr_cycles", 32'(cyc), 32'd2);
    chk("t3_sram_written", sram_rd(32'h400), 32'hCAFEF00D);
    do_req(1'b0, 1'b1, 32'h400, 32'h0, 2, cyc, rdat);
    chk("t3_hit_cycles", 32'(cyc), 32'd0);
    chk("t3_hit_data", rdat, 32'hCAFEF00D);

    // 4: LRU replacement within set 0
    do_req(1'b0, 1'b1, 32'h500, 32'h0, 2, cyc, rdat);
    chk("t4_500_miss", 32'(cyc), 32'd2);
    chk("t4_500_data", rdat, 32'hFAFF0500);
    do_req(1'b0, 1'b1, 32'h400, 32'h0, 2, cyc, rdat);
    chk("t4_400_hit", 32'(cyc), 32'd0);
    do_req(1'b0, 1'b1, 32'h600, 32'h0, 2, cyc, rdat);
    chk("t4_600_miss", 32'(cyc), 32'd2);
    do_req(1'b0, 1'b1, 32'h400, 32'h0, 2, cyc, rdat);
    chk("t4_400_hit2", 32'(cyc), 32'd0);
    chk("t4_400_data", rdat, 32'hCAFEF00D);
    do_req(1'b0, 1'b1, 32'h500, 32'h0, 2, cyc, rdat);
    chk("t4_500_evicted", 32'(cyc), 32'd2);
    chk("t4_model_600_gone", 32'(m_find(32'h600)), 32'hFFFFFFFF);

    // 5: simultaneous write and read -> write wins, no fill
    do_req(1'b1, 1'b1, 32'h408, 32'hA5A55A5A, 2, cyc, rdat);
    chk("t5_wr_cycles", 32'(cyc), 32'd2);
    chk("t5_sram_written", sram_rd(32'h408), 32'hA5A55A5A);
    do_req(1'b0, 1'b1, 32'h408, 32'h0, 2, cyc, rdat);
    chk("t5_rd_miss", 32'(cyc), 32'd2);
    chk("t5_rd_data", rdat, 32'hA5A55A5A);

    // 6: reset in the middle of a read miss
    do_req(1'b0, 1'b1, 32'h400, 32'h0, 2, cyc, rdat);
    chk("t6_pre_hit", 32'(cyc), 32'd0);
    chk_en = 1'b0;
    @(negedge clk);
    mif.rdEn = 1'b1; mif.address = 32'h700; sram_lat = 50;
    repeat (2) @(negedge clk);
    #2;
    chk("t6_in_rd_miss", 32'(dbg_state), 32'(ST_RD_MISS));
    chk("t6_rdEn_before", 32'(sif.sram_rdEn), 32'h1);
    #1 rst = 1'b0;
    #1;
    chk("t6_rdEn_async", 32'(sif.sram_rdEn), 32'h0);
    chk("t6_state_async", 32'(dbg_state), 32'(ST_IDLE));
    chk("t6_hitCount_rst", 32'(hitCount), 32'h0);
    mif.rdEn = 1'b0;
    @(negedge clk);
    rst = 1'b1; m_clear(); k = 0; chk_en = 1'b1;
    do_req(1'b0, 1'b1, 32'h400, 32'h0, 2, cyc, rdat);
    chk("t6_post_miss", 32'(cyc), 32'd2);
    chk("t6_post_data", rdat, 32'hCAFEF00D);

    repeat (2) @(negedge clk);
    #4;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
